// File: rtl/controle_busca_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// opcode constants and default widths.
package controle_busca_pkg;

  localparam int ADDR_W_PADRAO = 32;
  localparam int DATA_W_PADRAO = 32;

  localparam logic [4:0] OPC_HALT = 5'd18;
  localparam logic [4:0] OPC_JUMP = 5'd16;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    EXECUTA = 2'b01,
    PARADO  = 2'b10,
    ERRO    = 2'b11
  } estado_t;

  function automatic logic opcode_igual(input logic [31:0] palavra, input logic [4:0] opc);
    return palavra[31:27] == opc;
  endfunction

endpackage

// File: rtl/mux_memoria_instr.sv
// Memory port mux: loader owns the port while not running, fetch owns it while running.
module mux_memoria_instr #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 151
) (
  input  logic              i_executando,
  input  logic              i_carga_valid,
  input  logic [ADDR_W-1:0] i_carga_endereco,
  input  logic [DATA_W-1:0] i_carga_dado,
  input  logic [ADDR_W-1:0] i_pc_prox,
  output logic              o_carga_ready,
  output logic [ADDR_W-1:0] o_mem_endereco,
  output logic              o_mem_escrita,
  output logic [DATA_W-1:0] o_mem_dado
);

  logic w_endereco_ok;

  assign w_endereco_ok  = i_carga_endereco < ADDR_W'(MEM_DEPTH);
  assign o_carga_ready  = ~i_executando;
  assign o_mem_endereco = i_executando ? i_pc_prox : i_carga_endereco;
  assign o_mem_dado     = i_executando ? '0 : i_carga_dado;
  // Out-of-range loader writes are accepted (ready) but silently dropped.
  assign o_mem_escrita  = i_carga_valid & o_carga_ready & w_endereco_ok;

endmodule

// File: rtl/controle_busca.sv
// Fetch sequencer: owns the PC, arbitrates the instruction memory between loader
// and fetch, and handles jumps, stalls, HALT and out-of-range PC trapping.
module controle_busca
  import controle_busca_pkg::*;
#(
  parameter int                ADDR_W    = controle_busca_pkg::ADDR_W_PADRAO,
  parameter int                DATA_W    = controle_busca_pkg::DATA_W_PADRAO,
  parameter int unsigned       MEM_DEPTH = 151,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(1),
  parameter logic [4:0]        OPC_HALT  = controle_busca_pkg::OPC_HALT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              carga_valid,
  input  logic [ADDR_W-1:0] carga_endereco,
  input  logic [DATA_W-1:0] carga_dado,
  output logic              carga_ready,
  input  logic              iniciar,
  input  logic              parar,
  input  logic              desvio_valid,
  input  logic [ADDR_W-1:0] desvio_alvo,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic              mem_escrita,
  output logic [DATA_W-1:0] mem_dado,
  input  logic [DATA_W-1:0] mem_instrucao,
  output logic [DATA_W-1:0] instrucao,
  output logic              instrucao_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        estado,
  output logic              erro
);

  // Loader handshake: a write transfers on a rising edge when carga_valid and
  // carga_ready are both high; carga_ready depends only on state, never on carga_valid.
  estado_t           r_estado;
  logic [ADDR_W-1:0] r_pc_prox;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instrucao;
  logic              r_instrucao_valid;
  logic              r_erro;
  logic              w_executando;
  logic              w_fora_faixa;
  logic              w_eh_halt;

  assign w_executando = (r_estado == EXECUTA);
  assign w_fora_faixa = r_pc_prox >= ADDR_W'(MEM_DEPTH);
  assign w_eh_halt    = opcode_igual(32'(mem_instrucao), OPC_HALT);

  mux_memoria_instr #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mux (
    .i_executando     (w_executando),
    .i_carga_valid    (carga_valid),
    .i_carga_endereco (carga_endereco),
    .i_carga_dado     (carga_dado),
    .i_pc_prox        (r_pc_prox),
    .o_carga_ready    (carga_ready),
    .o_mem_endereco   (mem_endereco),
    .o_mem_escrita    (mem_escrita),
    .o_mem_dado       (mem_dado)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado          <= OCIOSO;
      r_pc_prox         <= RESET_PC;
      r_pc              <= '0;
      r_instrucao       <= '0;
      r_instrucao_valid <= 1'b0;
      r_erro            <= 1'b0;
    end else begin
      case (r_estado)
        EXECUTA: begin
          if (w_fora_faixa) begin
            r_instrucao_valid <= 1'b0;
            r_erro            <= 1'b1;
            r_estado          <= ERRO;
          end else if (desvio_valid) begin
            // The word read this cycle belongs to the wrong path: squash it.
            r_pc_prox         <= desvio_alvo;
            r_instrucao_valid <= 1'b0;
          end else if (parar) begin
            r_instrucao_valid <= 1'b0;
          end else begin
            r_instrucao       <= mem_instrucao;
            r_pc              <= r_pc_prox;
            r_instrucao_valid <= 1'b1;
            r_pc_prox         <= r_pc_prox + ADDR_W'(1);
            if (w_eh_halt) r_estado <= PARADO;
          end
        end
        default: begin
          r_instrucao_valid <= 1'b0;
          if (iniciar) begin
            r_estado  <= EXECUTA;
            r_pc_prox <= RESET_PC;
            r_erro    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign instrucao       = r_instrucao;
  assign instrucao_valid = r_instrucao_valid;
  assign pc              = r_pc;
  assign estado          = r_estado;
  assign erro            = r_erro;

endmodule

// File: tb/tb_controle_busca.sv
// Bench for controle_busca: behavioural model compared every cycle plus directed literal checks.
module tb_controle_busca;

  localparam int unsigned MEM_DEPTH = 151;

  logic        clock = 1'b0;
  logic        reset;
  logic        carga_valid;
  logic [31:0] carga_endereco;
  logic [31:0] carga_dado;
  logic        carga_ready;
  logic        iniciar;
  logic        parar;
  logic        desvio_valid;
  logic [31:0] desvio_alvo;
  logic [31:0] mem_endereco;
  logic        mem_escrita;
  logic [31:0] mem_dado;
  logic [31:0] mem_instrucao;
  logic [31:0] instrucao;
  logic        instrucao_valid;
  logic [31:0] pc;
  logic [1:0]  estado;
  logic        erro;

  int n_cmp = 0;
  int n_err = 0;
  logic check_en = 1'b0;

  always #5 clock = ~clock;

  controle_busca dut (
    .clock           (clock),
    .reset           (reset),
    .carga_valid     (carga_valid),
    .carga_endereco  (carga_endereco),
    .carga_dado      (carga_dado),
    .carga_ready     (carga_ready),
    .iniciar         (iniciar),
    .parar           (parar),
    .desvio_valid    (desvio_valid),
    .desvio_alvo     (desvio_alvo),
    .mem_endereco    (mem_endereco),
    .mem_escrita     (mem_escrita),
    .mem_dado        (mem_dado),
    .mem_instrucao   (mem_instrucao),
    .instrucao       (instrucao),
    .instrucao_valid (instrucao_valid),
    .pc              (pc),
    .estado          (estado),
    .erro            (erro)
  );

  // Instruction memory attached to the DUT port (deeper than MEM_DEPTH so stray writes stick).
  logic [31:0] tb_mem [0:255] = '{default: 32'h0};
  assign mem_instrucao = (mem_endereco < 32'd256) ? tb_mem[mem_endereco[7:0]] : 32'hDEAD_BEEF;
  always @(posedge clock) begin
    if (mem_escrita && mem_endereco < 32'd256) tb_mem[mem_endereco[7:0]] <= mem_dado;
  end

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 running, 2 halted, 3 error (same numbering as estado).
  logic [31:0] model_mem [0:255] = '{default: 32'h0};
  int          m_mode;
  logic [31:0] m_next, m_pc, m_instr;
  logic        m_valid, m_erro;

  task automatic model_reset();
    m_mode = 0; m_next = 32'd1; m_pc = 32'd0; m_instr = 32'd0; m_valid = 1'b0; m_erro = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (m_mode != 1) begin
      if (carga_valid && carga_endereco < MEM_DEPTH) model_mem[carga_endereco[7:0]] = carga_dado;
      m_valid = 1'b0;
      if (iniciar) begin
        m_mode = 1; m_next = 32'd1; m_erro = 1'b0;
      end
    end else if (m_next >= MEM_DEPTH) begin
      m_mode = 3; m_erro = 1'b1; m_valid = 1'b0;
    end else if (desvio_valid) begin
      m_next = desvio_alvo; m_valid = 1'b0;
    end else if (parar) begin
      m_valid = 1'b0;
    end else begin
      w = model_mem[m_next[7:0]];
      m_instr = w; m_pc = m_next; m_valid = 1'b1; m_next = m_next + 32'd1;
      if (w[31:27] == 5'd18) m_mode = 2;
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("m_estado", 32'(estado), 32'(m_mode));
      chk("m_pc", pc, m_pc);
      chk("m_instrucao", instrucao, m_instr);
      chk("m_valid", 32'(instrucao_valid), 32'(m_valid));
      chk("m_erro", 32'(erro), 32'(m_erro));
      chk("m_ready", 32'(carga_ready), 32'(m_mode != 1));
      chk("m_mem_endereco", mem_endereco, (m_mode == 1) ? m_next : carga_endereco);
      chk("m_mem_escrita", 32'(mem_escrita),
          32'(m_mode != 1 && carga_valid && carga_endereco < MEM_DEPTH));
      if (m_mode != 1) chk("m_mem_dado", mem_dado, carga_dado);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    carga_valid = 1'b1; carga_endereco = a; carga_dado = d;
    tick();
    carga_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; carga_valid = 1'b0; carga_endereco = '0; carga_dado = '0;
    iniciar = 1'b0; parar = 1'b0; desvio_valid = 1'b0; desvio_alvo = '0;
    tick(); tick();
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instrucao, 32'd0);
    chk("rst_valid", 32'(instrucao_valid), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    chk("rst_ready", 32'(carga_ready), 32'd1);
    reset = 1'b1; check_en = 1'b1;

    // Short program ending in HALT.
    load(32'd1, 32'h1000_0003);
    load(32'd2, 32'h0800_0000);
    load(32'd3, 32'h9000_0000);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    chk("start_estado", 32'(estado), 32'd1);
    chk("start_valid", 32'(instrucao_valid), 32'd0);
    tick(); chk("run_pc1", pc, 32'd1); chk("run_w1", instrucao, 32'h1000_0003);
    chk("run_v1", 32'(instrucao_valid), 32'd1);
    tick(); chk("run_pc2", pc, 32'd2); chk("run_v2", 32'(instrucao_valid), 32'd1);
    tick(); chk("run_pc3", pc, 32'd3); chk("halt_w", instrucao, 32'h9000_0000);
    chk("halt_v", 32'(instrucao_valid), 32'd1); chk("halt_estado", 32'(estado), 32'd2);
    tick(); chk("parado_v", 32'(instrucao_valid), 32'd0); chk("parado_estado", 32'(estado), 32'd2);

    // Straight-line program 1..25 for branch/stall tests.
    load(32'd3, 32'h0800_0003);
    for (int i = 4; i <= 25; i++) load(32'(i), 32'h0800_0000 | 32'(i));
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    repeat (4) tick();
    chk("pre_desvio_pc", pc, 32'd4);
    desvio_valid = 1'b1; desvio_alvo = 32'd20; tick(); desvio_valid = 1'b0;
    chk("squash_v", 32'(instrucao_valid), 32'd0); chk("squash_pc", pc, 32'd4);
    tick(); chk("alvo_pc", pc, 32'd20); chk("alvo_w", instrucao, 32'h0800_0014);
    chk("alvo_v", 32'(instrucao_valid), 32'd1);
    desvio_valid = 1'b1; parar = 1'b1; desvio_alvo = 32'd10; tick();
    desvio_valid = 1'b0; parar = 1'b0;
    chk("desvio_parar_v", 32'(instrucao_valid), 32'd0);
    tick(); chk("desvio_parar_pc", pc, 32'd10); chk("desvio_parar_vv", 32'(instrucao_valid), 32'd1);

    parar = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", pc, 32'd10); chk("stall_w", instrucao, 32'h0800_000A);
      chk("stall_v", 32'(instrucao_valid), 32'd0);
    end
    parar = 1'b0;
    tick(); chk("resume_pc", pc, 32'd11); chk("resume_v", 32'(instrucao_valid), 32'd1);

    // Loader write while running must be ignored.
    carga_valid = 1'b1; carga_endereco = 32'd7; carga_dado = 32'hFFFF_FFFF; #1;
    chk("exec_wr", 32'(mem_escrita), 32'd0); chk("exec_ready", 32'(carga_ready), 32'd0);
    tick(); carga_valid = 1'b0;
    desvio_valid = 1'b1; desvio_alvo = 32'd7; tick(); desvio_valid = 1'b0;
    tick(); chk("m7_intacto", instrucao, 32'h0800_0007); chk("m7_pc", pc, 32'd7);

    // Out-of-range target traps.
    desvio_valid = 1'b1; desvio_alvo = 32'd200; tick(); desvio_valid = 1'b0;
    chk("pre_erro_estado", 32'(estado), 32'd1);
    tick(); chk("erro_estado", 32'(estado), 32'd3); chk("erro_flag", 32'(erro), 32'd1);
    chk("erro_v", 32'(instrucao_valid), 32'd0);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    chk("restart_erro", 32'(erro), 32'd0); chk("restart_estado", 32'(estado), 32'd1);
    tick(); chk("restart_pc", pc, 32'd1); chk("restart_v", 32'(instrucao_valid), 32'd1);
    tick(); tick();

    // Asynchronous reset between edges.
    #2; reset = 1'b0; #1;
    chk("arst_estado", 32'(estado), 32'd0); chk("arst_pc", pc, 32'd0);
    chk("arst_instr", instrucao, 32'd0); chk("arst_valid", 32'(instrucao_valid), 32'd0);
    chk("arst_erro", 32'(erro), 32'd0);
    tick(); reset = 1'b1;
    tick(); tick(); chk("idle_estado", 32'(estado), 32'd0); chk("idle_v", 32'(instrucao_valid), 32'd0);

    // Out-of-range write dropped; start with a simultaneous write.
    carga_valid = 1'b1; carga_endereco = 32'd151; carga_dado = 32'h9000_0000; #1;
    chk("wr151", 32'(mem_escrita), 32'd0); chk("wr151_ready", 32'(carga_ready), 32'd1);
    tick(); carga_valid = 1'b0;
    chk("m151_intacto", tb_mem[151], 32'd0);
    iniciar = 1'b1; carga_valid = 1'b1; carga_endereco = 32'd1; carga_dado = 32'h9000_0001; #1;
    chk("wr_start", 32'(mem_escrita), 32'd1);
    tick(); iniciar = 1'b0; carga_valid = 1'b0;
    chk("wr_start_estado", 32'(estado), 32'd1);
    tick(); chk("wr_start_pc", pc, 32'd1); chk("wr_start_w", instrucao, 32'h9000_0001);
    chk("wr_start_v", 32'(instrucao_valid), 32'd1); chk("wr_start_halt", 32'(estado), 32'd2);
    tick();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
